// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types and key layout for the 4x4 hex keypad scanner.
// KEY_MAP[row][col] follows the physical layout 1-2-3-A / 4-5-6-B / 7-8-9-C / 0-F-E-D.
package kypd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } kypd_state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } round_res_e;

    // Packed as [row][col][nibble]; index 0 is the least-significant slot.
    localparam logic [3:0][3:0][3:0] KEY_MAP = {
        {4'hD, 4'hE, 4'hF, 4'h0},
        {4'hC, 4'h9, 4'h8, 4'h7},
        {4'hB, 4'h6, 4'h5, 4'h4},
        {4'hA, 4'h3, 4'h2, 4'h1}
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[row][col];
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad pins plus the key-entry outputs of keypad_scan.
// master is the scanner side; slave is the keypad/display side.
interface keypad_scan_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] value;

    modport master (
        input  row_in,
        input  clear,
        output col_out,
        output key_code,
        output key_valid,
        output key_held,
        output value
    );

    modport slave (
        output row_in,
        output clear,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  value
    );
endinterface

// File: rtl/kypd_sync.sv
// kypd_sync: parameterised-width two-flop synchronizer with a synchronous reset value.
module kypd_sync #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: column-multiplexed 4x4 hex keypad scanner with whole-round debounce.
// Accepted keys strobe key_valid and shift into the 16-bit entry register.
module keypad_scan
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic           CLK100MHZ,
    input logic           RST,
    keypad_scan_if.master kp
);
    localparam int unsigned   TW        = $clog2(SCAN_TICKS);
    localparam int unsigned   CW        = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
    localparam logic [CW:0]   DB_TARGET = DEBOUNCE_SCANS[CW:0];

    logic [3:0]    rows_s;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    col_idx;
    logic          last_tick;
    logic [15:0]   hits_acc;
    logic [15:0]   hits_now;
    round_res_e    res_now;
    round_res_e    res_q;
    logic [3:0]    code_now;
    logic [3:0]    code_q;
    logic          round_done;

    kypd_state_e   state;
    kypd_state_e   state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW:0]   cnt_inc;
    logic [3:0]    cand;
    logic [3:0]    cand_n;
    logic          accept;
    logic          match_held;

    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic [15:0]   value_q;

    kypd_sync #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_sync (
        .clk (CLK100MHZ),
        .rst (RST),
        .d   (kp.row_in),
        .q   (rows_s)
    );

    assign last_tick  = (tick_cnt == LAST_TICK);
    assign kp.col_out = ~(4'b0001 << col_idx);

    // hits_now folds the current column's rows into the round so far; bit = row*4 + col.
    always_comb begin
        hits_now = hits_acc;
        for (int unsigned r = 0; r < 4; r++) begin
            hits_now[{r[1:0], col_idx}] = ~rows_s[r];
        end
        code_now = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (hits_now[i]) code_now = key_lookup(i[3:2], i[1:0]);
        end
        if (hits_now == '0)       res_now = NONE;
        else if ($onehot(hits_now)) res_now = SINGLE;
        else                      res_now = MULTI;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            tick_cnt   <= '0;
            col_idx    <= '0;
            hits_acc   <= '0;
            round_done <= 1'b0;
            res_q      <= NONE;
            code_q     <= '0;
        end else begin
            round_done <= 1'b0;
            if (last_tick) begin
                tick_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    hits_acc   <= '0;
                    res_q      <= res_now;
                    code_q     <= code_now;
                    round_done <= 1'b1;
                end else begin
                    hits_acc <= hits_now;
                end
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    assign cnt_inc    = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign match_held = (res_q == SINGLE) && (code_q == key_code_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (round_done) begin
            unique case (state)
                IDLE: begin
                    if (res_q == SINGLE) begin
                        cand_n = code_q;
                        cnt_n  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_n = PRESS_PENDING;
                        end
                    end
                end
                PRESS_PENDING: begin
                    if (res_q != SINGLE) begin
                        state_n = IDLE;
                    end else if (code_q == cand) begin
                        cnt_n = cnt_inc[CW-1:0];
                        if (cnt_inc >= DB_TARGET) begin
                            state_n = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        cand_n = code_q;
                        cnt_n  = CW'(1);
                    end
                end
                PRESSED: begin
                    if (!match_held) begin
                        // A single NONE round already satisfies a one-round release.
                        if (res_q == NONE && DEBOUNCE_SCANS == 1) begin
                            state_n = IDLE;
                        end else begin
                            state_n = RELEASE_PENDING;
                        end
                        cnt_n = (res_q == NONE) ? CW'(1) : '0;
                    end
                end
                RELEASE_PENDING: begin
                    if (match_held) begin
                        state_n = PRESSED;
                    end else if (res_q == NONE) begin
                        cnt_n = cnt_inc[CW-1:0];
                        if (cnt_inc >= DB_TARGET) state_n = IDLE;
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            value_q     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            key_valid_q <= accept;
            if (accept) key_code_q <= code_q;
            if (kp.clear)    value_q <= '0;
            else if (accept) value_q <= {value_q[11:0], code_q};
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state == PRESSED) || (state == RELEASE_PENDING);
    assign kp.value     = value_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the multiplexed seven-segment display path. The display block scans digits out; this block scans a 4x4 hex keypad (Pmod KYPD, 1-2-3-A / 4-5-6-B / 7-8-9-C / 0-F-E-D) in.
- Drives one column low at a time, samples the four rows, and debounces whole-scan results.
- Emits a one-cycle key strobe and maintains a 16-bit nibble-entry register that feeds the display's 16-bit value input directly.

Parameters:
- SCAN_TICKS, 100000, cycles each column is driven (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan rounds needed to accept a press or a release; must be >= 1.

Ports:
- CLK100MHZ  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- row_in  input  4  keypad rows; active-low, pulled up, asynchronous.
- col_out  output  4  keypad columns; active-low, exactly one bit low at all times.
- clear  input  1  synchronous clear of value.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high while the accepted key remains pressed.
- value  output  16  nibble-entry register; each new key shifts into [3:0].

Behaviour:
- Reset values:
  - col_out=4'b1110 (column 0 driven).
  - key_code=0, key_valid=0, key_held=0, value=16'h0000.
  - Tick counter, column index and debounce count = 0; state=IDLE.
  - The synchronizer flops reset to 4'b1111.
- row_in passes through a 2-flop synchronizer before any use.
- Column timing:
  - The tick counter runs 0..SCAN_TICKS-1.
  - On the last tick of a column period, the synchronized rows are sampled into the round accumulator.
  - The column index then advances 0->1->2->3->0.
  - col_out = ~(1 << index).
- Round: 4 column periods, i.e. 4*SCAN_TICKS cycles.
- Round result at the end of column 3, one of:
  - NONE: no row was low in any column.
  - SINGLE(code): exactly one (row,col) was low; code = KEY_MAP[row][col].
  - MULTI: two or more were low.
- Debounce FSM, evaluated once per round, in the cycle after the column-3 sample:
  - IDLE:
    - SINGLE(k) -> PRESS_PENDING, cand=k, cnt=1.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED and accept k.
  - PRESS_PENDING:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS -> PRESSED and accept cand.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - SINGLE(key_code): stay.
    - Any other result -> RELEASE_PENDING, cnt=1 if the result was NONE, else cnt=0.
  - RELEASE_PENDING:
    - SINGLE(key_code) -> PRESSED.
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held=0.
    - SINGLE(other) or MULTI: cnt=0. No rollover; a new key requires a full release first.
- Accept, all in the same cycle:
  - key_code<=k, key_valid<=1 for exactly one cycle, key_held<=1.
  - value<={value[11:0],k}. The top nibble is discarded.
- clear:
  - value<=0 in any cycle.
  - If clear coincides with an accept, value=0 (clear wins), but key_valid and key_code still update.
- RST mid-press or mid-scan: everything returns to reset values next cycle, with no key_valid pulse. A key still held after reset must be debounced afresh and is then accepted.
- key_valid latency: the pulse appears 1 cycle after the final column-3 sample of the accepting round.

Decomposition:
- Package kypd_pkg:
  - KEY_MAP[4][4] constant: row0 {1,2,3,A}, row1 {4,5,6,B}, row2 {7,8,9,C}, row3 {0,F,E,D}; columns 0..3 left to right.
  - State enum {IDLE, PRESS_PENDING, PRESSED, RELEASE_PENDING}.
  - Round-result enum {NONE, SINGLE, MULTI}.
- Sub-module kypd_sync: parameterised-width 2-flop synchronizer with synchronous reset value.
- Scan and debounce logic stay in keypad_scan.

Test Plan (SCAN_TICKS=4, DEBOUNCE_SCANS=2; round = 16 cycles; the bench keypad model pulls row r low iff col_out[c]==0 and key (r,c) is pressed):
- Reset -> col_out=4'b1110; key_valid=0, key_held=0, value=16'h0000. col_out then walks 1101, 1011, 0111 every 4 cycles and wraps.
- Press '5' (r1,c1) for 4 rounds, then release for 3 rounds -> exactly one key_valid pulse, 1 cycle after round 2 ends; key_code=5, value=16'h0005. key_held drops 2 NONE rounds after release.
- '5' pressed only in alternating rounds -> no key_valid; value stays 16'h0000.
- Enter 1, 2, 3, A, each with a full release between -> value=16'h123A. Then enter 4 -> value=16'h23A4.
- Press '1' and '2' together for 4 rounds -> no key_valid. Then press '7' while '5' is still held -> no pulse for '7' until '5' is fully released.
- Assert clear in the same cycle as the 'C' acceptance -> value=0, key_valid=1, key_code=C. Assert RST midway through a press round -> reset outputs next cycle and no pulse for that round.
